// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing one single-ported memory bus between IF fetch and MEM load/store.
// Optional performance counters are added when ARB_PERF_CNT_EN is defined.
`ifndef BUS_NONE
`define BUS_NONE  2'b00
`endif
`ifndef BUS_LOAD
`define BUS_LOAD  2'b01
`endif
`ifndef BUS_STORE
`define BUS_STORE 2'b10
`endif

module mem_bus_arbiter #(
  parameter int unsigned D_STREAK_MAX = 4,
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  input  logic [1:0]    d_cmd,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_stall,
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
`ifdef ARB_PERF_CNT_EN
  output logic [15:0]   perf_conflicts,
  output logic [15:0]   perf_if_wait,
`endif
  input  logic          mem_ack
);
  localparam int unsigned SW = $clog2(D_STREAK_MAX + 1);
  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_D = 2'd1,
    GNT_I = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          grant_d, grant_i, release_bus;
  logic          d_pend;
  logic [CW-1:0] cmd_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] streak_q;
  logic [DW-1:0] if_rdata_q, d_rdata_q;
  logic [DW-1:0] d_rdata_now;

  assign d_pend = (d_cmd != `BUS_NONE);

  // Arbitration: data first unless IF has waited through a full D streak
  always_comb begin
    state_d     = state_q;
    grant_d     = 1'b0;
    grant_i     = 1'b0;
    release_bus = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_pend && (!if_req || (streak_q < SW'(D_STREAK_MAX)))) begin
          state_d = GNT_D;
          grant_d = 1'b1;
        end else if (if_req) begin
          state_d = GNT_I;
          grant_i = 1'b1;
        end
      end
      GNT_D: begin
        if (mem_ack) begin
          if (if_req) begin
            state_d = GNT_I;
            grant_i = 1'b1;
          end else begin
            state_d     = IDLE;
            release_bus = 1'b1;
          end
        end
      end
      GNT_I: begin
        if (mem_ack) begin
          if (d_pend) begin
            state_d = GNT_D;
            grant_d = 1'b1;
          end else begin
            state_d     = IDLE;
            release_bus = 1'b1;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        release_bus = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched command presented to memory until it acknowledges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q   <= `BUS_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant_d) begin
      cmd_q   <= d_cmd;
      addr_q  <= d_addr;
      wdata_q <= (d_cmd == `BUS_STORE) ? d_wdata : '0;
    end else if (grant_i) begin
      cmd_q   <= `BUS_LOAD;
      addr_q  <= if_addr;
      wdata_q <= '0;
    end else if (release_bus) begin
      cmd_q   <= `BUS_NONE;
    end
  end

  // Consecutive D grants while a fetch is waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= '0;
    end else if (grant_d) begin
      if (!if_req) begin
        streak_q <= '0;
      end else if (streak_q < SW'(D_STREAK_MAX)) begin
        streak_q <= streak_q + SW'(1);
      end
    end else if (grant_i) begin
      streak_q <= '0;
    end
  end

  assign if_ack      = (state_q == GNT_I) && mem_ack;
  assign d_ack       = (state_q == GNT_D) && mem_ack;
  assign d_rdata_now = (cmd_q == `BUS_STORE) ? '0 : mem_rdata;
  assign if_rdata    = if_ack ? mem_rdata : if_rdata_q;
  assign d_rdata     = d_ack ? d_rdata_now : d_rdata_q;
  assign if_stall    = if_req && !if_ack;
  assign d_stall     = d_pend && !d_ack;
  assign mem_cmd     = cmd_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;

  // Read data holds its last delivered value between acks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (if_ack) if_rdata_q <= mem_rdata;
      if (d_ack)  d_rdata_q  <= d_rdata_now;
    end
  end

`ifdef ARB_PERF_CNT_EN
  localparam int unsigned PW = 16;
  logic [PW-1:0] conflicts_q, if_wait_q;

  // Saturating event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflicts_q <= '0;
      if_wait_q   <= '0;
    end else begin
      if ((state_q == IDLE) && if_req && d_pend && (conflicts_q != '1))
        conflicts_q <= conflicts_q + PW'(1);
      if (if_stall && (if_wait_q != '1))
        if_wait_q <= if_wait_q + PW'(1);
    end
  end

  assign perf_conflicts = conflicts_q;
  assign perf_if_wait   = if_wait_q;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a randomized
// run against a cycle-level behavioural model of the arbitration rules.
`ifndef BUS_NONE
`define BUS_NONE  2'b00
`endif
`ifndef BUS_LOAD
`define BUS_LOAD  2'b01
`endif
`ifndef BUS_STORE
`define BUS_STORE 2'b10
`endif

module tb_mem_bus_arbiter;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int          SMAX = 4;

  logic          clk;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          if_stall;
  logic [1:0]    d_cmd;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          d_stall;
  logic [1:0]    mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
`ifdef ARB_PERF_CNT_EN
  logic [15:0]   perf_conflicts;
  logic [15:0]   perf_if_wait;
`endif

  int checks   = 0;
  int failures = 0;

  mem_bus_arbiter #(.D_STREAK_MAX(SMAX), .AW(AW), .DW(DW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_ack(if_ack),
    .if_rdata(if_rdata),
    .if_stall(if_stall),
    .d_cmd(d_cmd),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_ack(d_ack),
    .d_rdata(d_rdata),
    .d_stall(d_stall),
    .mem_cmd(mem_cmd),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
`ifdef ARB_PERF_CNT_EN
    .perf_conflicts(perf_conflicts),
    .perf_if_wait(perf_if_wait),
`endif
    .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_cmd = `BUS_NONE;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    #12;
    checks++;
    if ({mem_cmd, mem_addr, mem_wdata} !== {`BUS_NONE, 32'h0, 32'h0}) begin
      failures++; $display("FAIL reset_mem got=%h/%h/%h exp=0/0/0", mem_cmd, mem_addr, mem_wdata);
    end
    checks++;
    if ({if_ack, d_ack, if_rdata, d_rdata} !== {2'b00, 64'h0}) begin
      failures++; $display("FAIL reset_acks got=%b%b %h %h exp=00 0 0", if_ack, d_ack, if_rdata, d_rdata);
    end
`ifdef ARB_PERF_CNT_EN
    checks++;
    if ({perf_conflicts, perf_if_wait} !== 32'h0) begin
      failures++; $display("FAIL reset_perf got=%h/%h exp=0/0", perf_conflicts, perf_if_wait);
    end
`endif
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    logic [DW-1:0] r;
    r = $urandom();
    @(posedge clk); #1; if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk);
    checks++;
    if (mem_cmd !== `BUS_NONE || if_stall !== 1'b1) begin
      failures++; $display("FAIL fetch_req got=cmd%h stall%b exp=cmd0 stall1", mem_cmd, if_stall);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (mem_cmd !== `BUS_LOAD || mem_addr !== 32'h40 || mem_wdata !== 32'h0) begin
      failures++; $display("FAIL fetch_grant got=%h/%h/%h exp=1/40/0", mem_cmd, mem_addr, mem_wdata);
    end
    checks++;
    if (if_ack !== 1'b0 || if_stall !== 1'b1) begin
      failures++; $display("FAIL fetch_wait got=ack%b stall%b exp=ack0 stall1", if_ack, if_stall);
    end
    @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = r;
    @(negedge clk);
    checks++;
    if (if_ack !== 1'b1 || if_rdata !== r || if_stall !== 1'b0 || d_ack !== 1'b0) begin
      failures++; $display("FAIL fetch_ack got=ack%b %h stall%b dack%b exp=ack1 %h stall0 dack0",
                           if_ack, if_rdata, if_stall, d_ack, r);
    end
    @(posedge clk); #1; mem_ack = 1'b0; if_req = 1'b0; mem_rdata = ~r;
    @(negedge clk);
    checks++;
    if (mem_cmd !== `BUS_NONE || if_ack !== 1'b0 || if_rdata !== r) begin
      failures++; $display("FAIL fetch_idle got=cmd%h ack%b %h exp=cmd0 ack0 %h", mem_cmd, if_ack, if_rdata, r);
    end
  endtask

  task automatic test_store_then_fetch();
    logic [DW-1:0] r;
    r = $urandom();
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h200;
    d_cmd = `BUS_STORE; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (d_stall !== 1'b1 || if_stall !== 1'b1 || mem_cmd !== `BUS_NONE) begin
      failures++; $display("FAIL st_req got=ds%b is%b cmd%h exp=ds1 is1 cmd0", d_stall, if_stall, mem_cmd);
    end
    @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = $urandom();
    @(negedge clk);
    checks++;
    if (mem_cmd !== `BUS_STORE || mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL st_grant got=%h/%h/%h exp=2/100/deadbeef", mem_cmd, mem_addr, mem_wdata);
    end
    checks++;
    if (d_ack !== 1'b1 || d_rdata !== 32'h0 || if_ack !== 1'b0) begin
      failures++; $display("FAIL st_ack got=dack%b %h iack%b exp=dack1 0 iack0", d_ack, d_rdata, if_ack);
    end
    @(posedge clk); #1; d_cmd = `BUS_NONE; mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_cmd !== `BUS_LOAD || mem_addr !== 32'h200 || mem_wdata !== 32'h0 || d_ack !== 1'b0) begin
      failures++; $display("FAIL st_handoff got=%h/%h/%h dack%b exp=1/200/0 dack0", mem_cmd, mem_addr, mem_wdata, d_ack);
    end
    @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = r;
    @(negedge clk);
    checks++;
    if (if_ack !== 1'b1 || if_rdata !== r) begin
      failures++; $display("FAIL st_fetch_ack got=ack%b %h exp=ack1 %h", if_ack, if_rdata, r);
    end
    @(posedge clk); #1; mem_ack = 1'b0; if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_cmd !== `BUS_NONE) begin
      failures++; $display("FAIL st_idle got=%h exp=0", mem_cmd);
    end
  endtask

  // Data and fetch both held with single-cycle memory: each completion hands off to the waiting side
  task automatic test_streak();
    int d_n, i_n;
    logic [AW-1:0] ea;
    d_n = 0; i_n = 0;
    @(posedge clk); #1;
    d_cmd = `BUS_LOAD; d_addr = 32'h1000; if_req = 1'b1; if_addr = 32'h2000; mem_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_cmd !== `BUS_NONE || if_ack !== 1'b0 || d_ack !== 1'b0) begin
      failures++; $display("FAIL idle_ack_ignored got=cmd%h i%b d%b exp=cmd0 i0 d0", mem_cmd, if_ack, d_ack);
    end
    for (int k = 0; k < 13; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (k % 2 == 0) begin
        ea = 32'h1000 + AW'(4 * d_n);
        checks++;
        if (mem_cmd !== `BUS_LOAD || mem_addr !== ea || d_ack !== 1'b1 || if_ack !== 1'b0) begin
          failures++; $display("FAIL streak_d%0d got=%h/%h d%b i%b exp=1/%h d1 i0", k, mem_cmd, mem_addr, d_ack, if_ack, ea);
        end
        d_n++; d_addr = 32'h1000 + AW'(4 * d_n);
        if (k == 12) d_cmd = `BUS_NONE;
      end else begin
        ea = 32'h2000 + AW'(4 * i_n);
        checks++;
        if (mem_cmd !== `BUS_LOAD || mem_addr !== ea || if_ack !== 1'b1 || d_ack !== 1'b0) begin
          failures++; $display("FAIL streak_i%0d got=%h/%h i%b d%b exp=1/%h i1 d0", k, mem_cmd, mem_addr, if_ack, d_ack, ea);
        end
        i_n++; if_addr = 32'h2000 + AW'(4 * i_n);
        if (k == 11) if_req = 1'b0;
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (mem_cmd !== `BUS_NONE || if_ack !== 1'b0 || d_ack !== 1'b0) begin
      failures++; $display("FAIL streak_end got=cmd%h i%b d%b exp=cmd0 i0 d0", mem_cmd, if_ack, d_ack);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_latency();
    int stalls;
    logic [DW-1:0] r;
    stalls = 0; r = $urandom();
    @(posedge clk); #1; d_cmd = `BUS_LOAD; d_addr = 32'h300;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (c == 3) begin mem_ack = 1'b1; mem_rdata = r; end
      end
      @(negedge clk);
      if (d_stall === 1'b1) stalls++;
      if (c > 0) begin
        checks++;
        if (mem_cmd !== `BUS_LOAD || mem_addr !== 32'h300) begin
          failures++; $display("FAIL lat_hold%0d got=%h/%h exp=1/300", c, mem_cmd, mem_addr);
        end
      end
      if (c < 3) begin
        checks++;
        if (d_ack !== 1'b0) begin
          failures++; $display("FAIL lat_early_ack%0d got=%b exp=0", c, d_ack);
        end
      end
    end
    checks++;
    if (d_ack !== 1'b1 || d_rdata !== r) begin
      failures++; $display("FAIL lat_ack got=%b %h exp=1 %h", d_ack, d_rdata, r);
    end
    checks++;
    if (stalls != 3) begin
      failures++; $display("FAIL lat_stall_cycles got=%0d exp=3", stalls);
    end
    @(posedge clk); #1; mem_ack = 1'b0; d_cmd = `BUS_NONE;
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] r;
    r = $urandom();
    @(posedge clk); #1; d_cmd = `BUS_STORE; d_addr = 32'h500; d_wdata = 32'h12345678;
    @(posedge clk); #1; if_req = 1'b1; if_addr = 32'h600;
    @(negedge clk);
    checks++;
    if (mem_cmd !== `BUS_STORE || mem_wdata !== 32'h12345678) begin
      failures++; $display("FAIL rst_pre got=%h/%h exp=2/12345678", mem_cmd, mem_wdata);
    end
    #2; rst_n = 1'b0; #1;
    checks++;
    if ({mem_cmd, mem_addr, mem_wdata} !== {`BUS_NONE, 32'h0, 32'h0}) begin
      failures++; $display("FAIL rst_mid_mem got=%h/%h/%h exp=0/0/0", mem_cmd, mem_addr, mem_wdata);
    end
    checks++;
    if ({if_ack, d_ack, if_rdata, d_rdata} !== {2'b00, 64'h0}) begin
      failures++; $display("FAIL rst_mid_out got=%b%b %h %h exp=00 0 0", if_ack, d_ack, if_rdata, d_rdata);
    end
`ifdef ARB_PERF_CNT_EN
    checks++;
    if ({perf_conflicts, perf_if_wait} !== 32'h0) begin
      failures++; $display("FAIL rst_mid_perf got=%h/%h exp=0/0", perf_conflicts, perf_if_wait);
    end
`endif
    d_cmd = `BUS_NONE;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (mem_cmd !== `BUS_LOAD || mem_addr !== 32'h600) begin
      failures++; $display("FAIL rst_regrant got=%h/%h exp=1/600", mem_cmd, mem_addr);
    end
    @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = r;
    @(negedge clk);
    checks++;
    if (if_ack !== 1'b1 || if_rdata !== r) begin
      failures++; $display("FAIL rst_fetch_ack got=%b %h exp=1 %h", if_ack, if_rdata, r);
    end
    @(posedge clk); #1; mem_ack = 1'b0; if_req = 1'b0;
  endtask

  // Random requesters and memory latency against a behavioural model of the arbitration rules
  task automatic test_random();
    int owner, streak, cyc, lat, g;
    logic [1:0]    lcmd;
    logic [AW-1:0] laddr;
    logic [DW-1:0] lwdata, hif, hd, e_ird, e_drd;
    logic          e_iack, e_dack, e_is, e_ds, if_done, d_done, d_pend;
    int unsigned   conf_cnt, wait_cnt;
    owner = 0; streak = 0; cyc = 0; lat = 1; lcmd = `BUS_NONE; laddr = '0; lwdata = '0;
    hif = '0; hd = '0; if_done = 1'b0; d_done = 1'b0; conf_cnt = 0; wait_cnt = 0;
    @(negedge clk);
    rst_n = 1'b0; if_req = 1'b0; d_cmd = `BUS_NONE; mem_ack = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      if (!if_req || if_done) begin
        if_req  = ($urandom_range(0, 2) == 0);
        if_addr = $urandom();
      end
      if (d_cmd == `BUS_NONE || d_done) begin
        case ($urandom_range(0, 3))
          0:       d_cmd = `BUS_LOAD;
          1:       d_cmd = `BUS_STORE;
          default: d_cmd = `BUS_NONE;
        endcase
        d_addr = $urandom(); d_wdata = $urandom();
      end
      mem_rdata = $urandom();
      if (owner != 0) begin
        cyc++;
        mem_ack = (cyc >= lat);
      end else begin
        mem_ack = ($urandom_range(0, 7) == 0);
      end
      @(negedge clk);
      d_pend = (d_cmd != `BUS_NONE);
      e_iack = (owner == 2) && mem_ack;
      e_dack = (owner == 1) && mem_ack;
      e_ird  = e_iack ? mem_rdata : hif;
      e_drd  = e_dack ? ((lcmd == `BUS_STORE) ? '0 : mem_rdata) : hd;
      e_is   = if_req && !e_iack;
      e_ds   = d_pend && !e_dack;
      checks++;
      if ({if_ack, d_ack, if_stall, d_stall} !== {e_iack, e_dack, e_is, e_ds}) begin
        failures++; $display("FAIL rnd_ctrl@%0d got=%b%b%b%b exp=%b%b%b%b", n,
                             if_ack, d_ack, if_stall, d_stall, e_iack, e_dack, e_is, e_ds);
      end
      checks++;
      if (if_rdata !== e_ird || d_rdata !== e_drd) begin
        failures++; $display("FAIL rnd_rdata@%0d got=%h/%h exp=%h/%h", n, if_rdata, d_rdata, e_ird, e_drd);
      end
      checks++;
      if (mem_cmd !== lcmd || (lcmd != `BUS_NONE && (mem_addr !== laddr || mem_wdata !== lwdata))) begin
        failures++; $display("FAIL rnd_mem@%0d got=%h/%h/%h exp=%h/%h/%h", n,
                             mem_cmd, mem_addr, mem_wdata, lcmd, laddr, lwdata);
      end
`ifdef ARB_PERF_CNT_EN
      checks++;
      if (perf_conflicts !== 16'(conf_cnt) || perf_if_wait !== 16'(wait_cnt)) begin
        failures++; $display("FAIL rnd_perf@%0d got=%0d/%0d exp=%0d/%0d", n,
                             perf_conflicts, perf_if_wait, conf_cnt, wait_cnt);
      end
`endif
      if (owner == 0 && if_req && d_pend && conf_cnt < 65535) conf_cnt++;
      if (e_is && wait_cnt < 65535) wait_cnt++;
      hif = e_ird; hd = e_drd; if_done = e_iack; d_done = e_dack;
      g = -1;
      if (owner == 0) begin
        if (d_pend && (!if_req || streak < SMAX)) g = 1;
        else if (if_req) g = 2;
      end else if (mem_ack) begin
        if (owner == 1) g = if_req ? 2 : 0;
        else            g = d_pend ? 1 : 0;
      end
      if (g == 1) begin
        owner = 1; lcmd = d_cmd; laddr = d_addr;
        lwdata = (d_cmd == `BUS_STORE) ? d_wdata : '0;
        streak = if_req ? ((streak < SMAX) ? streak + 1 : streak) : 0;
        cyc = 0; lat = $urandom_range(1, 4);
      end else if (g == 2) begin
        owner = 2; lcmd = `BUS_LOAD; laddr = if_addr; lwdata = '0;
        streak = 0; cyc = 0; lat = $urandom_range(1, 4);
      end else if (g == 0) begin
        owner = 0; lcmd = `BUS_NONE;
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_then_fetch();
    test_streak();
    test_latency();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
